// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up initialization sequencer
// (wait, precharge-all, auto refreshes, load mode, done).
module sdram_init_seq #(
  parameter int          T_WAIT      = 26600,
  parameter int          T_RP        = 3,
  parameter int          T_RFC       = 10,
  parameter int          T_MRD       = 3,
  parameter int          REFRESH_NUM = 8,
  parameter logic [12:0] MODE_VALUE  = 13'h0037
) (
  input  logic        clk_133,
  input  logic        rst_n,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_REF, S_TRFC, S_MRS, S_TMRD, S_DONE
  } state_t;

  localparam logic [3:0]  CMD_INHIBIT = 4'b1111;
  localparam logic [3:0]  CMD_NOP     = 4'b0111;
  localparam logic [3:0]  CMD_PRE     = 4'b0010;
  localparam logic [3:0]  CMD_REF     = 4'b0001;
  localparam logic [3:0]  CMD_MRS     = 4'b0000;
  localparam logic [12:0] ADDR_PALL   = 13'h0400;

  // Gap states exit when the counter is 0, so they load spacing-2
  // (the command cycle itself plus the final gap cycle).
  localparam logic [15:0] WAIT_LD  = 16'(T_WAIT - 1);
  localparam logic [15:0] TRP_LD   = 16'(T_RP - 2);
  localparam logic [15:0] TRFC_LD  = 16'(T_RFC - 2);
  localparam logic [15:0] TMRD_LD  = 16'(T_MRD - 2);
  localparam logic [3:0]  REF_LAST = 4'(REFRESH_NUM);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  ref_cnt, ref_n;
  logic        cke_q, done_q;
  logic [3:0]  cmd_q, cmd_n;
  logic [12:0] addr_q, addr_n;
  logic [1:0]  ba_q;

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    ref_n   = ref_cnt;
    cmd_n   = CMD_NOP;
    addr_n  = 13'd0;
    // cke still low means this edge produces cycle 0 of a fresh sequence.
    if (!cke_q) begin
      state_n = S_WAIT;
      cnt_n   = WAIT_LD;
      ref_n   = 4'd0;
    end else begin
      case (state)
        S_WAIT: if (cnt == 16'd0) state_n = S_PRE;
        S_PRE: begin
          state_n = S_TRP;
          cnt_n   = TRP_LD;
        end
        S_TRP:  if (cnt == 16'd0) state_n = S_REF;
        S_REF: begin
          state_n = S_TRFC;
          cnt_n   = TRFC_LD;
        end
        S_TRFC: if (cnt == 16'd0) state_n = (ref_cnt >= REF_LAST) ? S_MRS : S_REF;
        S_MRS: begin
          state_n = S_TMRD;
          cnt_n   = TMRD_LD;
        end
        S_TMRD: if (cnt == 16'd0) state_n = S_DONE;
        S_DONE: state_n = S_DONE;
        default: state_n = S_WAIT;
      endcase
      if (state_n == S_REF && ref_cnt != 4'hF) ref_n = ref_cnt + 4'd1;
    end
    case (state_n)
      S_PRE: begin
        cmd_n  = CMD_PRE;
        addr_n = ADDR_PALL;
      end
      S_REF: cmd_n = CMD_REF;
      S_MRS: begin
        cmd_n  = CMD_MRS;
        addr_n = MODE_VALUE;
      end
      default: cmd_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk_133) begin
    if (!rst_n) begin
      state   <= S_WAIT;
      cnt     <= 16'd0;
      ref_cnt <= 4'd0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_INHIBIT;
      addr_q  <= 13'd0;
      ba_q    <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ref_cnt <= ref_n;
      cke_q   <= 1'b1;
      cmd_q   <= cmd_n;
      addr_q  <= addr_n;
      ba_q    <= 2'd0;
      done_q  <= (state_n == S_DONE);
    end
  end

  assign sdram_cke   = cke_q;
  assign sdram_cs_n  = cmd_q[3];
  assign sdram_ras_n = cmd_q[2];
  assign sdram_cas_n = cmd_q[1];
  assign sdram_we_n  = cmd_q[0];
  assign sdram_addr  = addr_q;
  assign sdram_ba    = ba_q;
  assign init_done   = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard bench for sdram_init_seq: three
// instances (short params, minimum params, defaults) checked against hand timelines.
module tb_sdram_init_seq;

  localparam logic [3:0]  C_NOP = 4'b0111;
  localparam logic [3:0]  C_PRE = 4'b0010;
  localparam logic [3:0]  C_REF = 4'b0001;
  localparam logic [3:0]  C_MRS = 4'b0000;

  typedef struct {
    bit          kind;   // 0 = command, 1 = init_done rising
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        samp   [3];
  logic        cke_w  [3];
  logic        cs_w   [3];
  logic        ras_w  [3];
  logic        cas_w  [3];
  logic        we_w   [3];
  logic [12:0] addr_w [3];
  logic [1:0]  ba_w   [3];
  logic        done_w [3];
  logic        prev_done [3];
  int          cyc [3];
  ev_t         exp_q [3][$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sdram_init_seq #(.T_WAIT(10), .T_RP(3), .T_RFC(8), .T_MRD(2), .REFRESH_NUM(2)) u0 (
    .clk_133(clk), .rst_n(rst[0]), .sdram_cke(cke_w[0]), .sdram_cs_n(cs_w[0]),
    .sdram_ras_n(ras_w[0]), .sdram_cas_n(cas_w[0]), .sdram_we_n(we_w[0]),
    .sdram_addr(addr_w[0]), .sdram_ba(ba_w[0]), .init_done(done_w[0]));

  sdram_init_seq #(.T_WAIT(2), .T_RP(2), .T_RFC(2), .T_MRD(2), .REFRESH_NUM(1)) u1 (
    .clk_133(clk), .rst_n(rst[1]), .sdram_cke(cke_w[1]), .sdram_cs_n(cs_w[1]),
    .sdram_ras_n(ras_w[1]), .sdram_cas_n(cas_w[1]), .sdram_we_n(we_w[1]),
    .sdram_addr(addr_w[1]), .sdram_ba(ba_w[1]), .init_done(done_w[1]));

  sdram_init_seq u2 (
    .clk_133(clk), .rst_n(rst[2]), .sdram_cke(cke_w[2]), .sdram_cs_n(cs_w[2]),
    .sdram_ras_n(ras_w[2]), .sdram_cas_n(cas_w[2]), .sdram_we_n(we_w[2]),
    .sdram_addr(addr_w[2]), .sdram_ba(ba_w[2]), .init_done(done_w[2]));

  // Mirror of what the DUT sampled on rst_n at each edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) samp[i] <= rst[i];
  end

  task automatic compare_ev(int i, bit kind, logic [3:0] cmd);
    ev_t e;
    checks++;
    if (exp_q[i].size() == 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got kind=%0d cyc=%0d cmd=%b addr=%h, expected none",
               i, kind, cyc[i], cmd, addr_w[i]);
    end else begin
      e = exp_q[i].pop_front();
      if (e.kind != kind || e.cyc != cyc[i] || e.cmd != cmd || e.addr != addr_w[i] || ba_w[i] != 2'd0) begin
        errors++;
        $display("FAIL event dut%0d: got kind=%0d cyc=%0d cmd=%b addr=%h ba=%0d, expected kind=%0d cyc=%0d cmd=%b addr=%h ba=0",
                 i, kind, cyc[i], cmd, addr_w[i], ba_w[i], e.kind, e.cyc, e.cmd, e.addr);
      end
    end
  endtask

  // Monitor: every non-NOP command and every init_done rise is popped from the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [3:0] cmd;
      cmd = {cs_w[i], ras_w[i], cas_w[i], we_w[i]};
      checks++;
      if (!samp[i]) begin
        cyc[i] = -1;
        if (cke_w[i] !== 1'b0 || cmd !== 4'b1111 || done_w[i] !== 1'b0 ||
            addr_w[i] !== 13'd0 || ba_w[i] !== 2'd0) begin
          errors++;
          $display("FAIL reset_vals dut%0d: got cke=%b cmd=%b done=%b addr=%h ba=%0d, expected cke=0 cmd=1111 done=0 addr=0 ba=0",
                   i, cke_w[i], cmd, done_w[i], addr_w[i], ba_w[i]);
        end
        prev_done[i] = 1'b0;
      end else begin
        cyc[i]++;
        if (cke_w[i] !== 1'b1) begin
          errors++;
          $display("FAIL cke dut%0d cyc=%0d: got %b, expected 1", i, cyc[i], cke_w[i]);
        end
        if (cmd != C_NOP) compare_ev(i, 1'b0, cmd);
        else begin
          checks++;
          if (addr_w[i] !== 13'd0 || ba_w[i] !== 2'd0) begin
            errors++;
            $display("FAIL nop_addr dut%0d cyc=%0d: got addr=%h ba=%0d, expected 0/0",
                     i, cyc[i], addr_w[i], ba_w[i]);
          end
        end
        if (done_w[i] && !prev_done[i]) compare_ev(i, 1'b1, C_NOP);
        if (prev_done[i] && !done_w[i]) begin
          checks++;
          errors++;
          $display("FAIL done_hold dut%0d cyc=%0d: got 0, expected 1", i, cyc[i]);
        end
        prev_done[i] = done_w[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(int i, bit kind, int c, logic [3:0] cmd, logic [12:0] addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cmd  = cmd;
    e.addr = addr;
    exp_q[i].push_back(e);
  endtask

  task automatic push_short_seq();
    push(0, 1'b0, 10, C_PRE, 13'h0400);
    push(0, 1'b0, 13, C_REF, 13'h0000);
    push(0, 1'b0, 21, C_REF, 13'h0000);
    push(0, 1'b0, 29, C_MRS, 13'h0037);
    push(0, 1'b1, 31, C_NOP, 13'h0000);
  endtask

  task automatic wait_done(int i, int bound);
    int k;
    k = 0;
    while (!done_w[i] && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (!done_w[i]) begin
      errors++;
      $display("FAIL timeout_done dut%0d: got init_done=0 after %0d cycles, expected 1", i, bound);
    end
  endtask

  task automatic hold_reset(int i, int n);
    rst[i] = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic run0();
    int k;
    hold_reset(0, 5);
    // First run is aborted between the two refreshes.
    push(0, 1'b0, 10, C_PRE, 13'h0400);
    push(0, 1'b0, 13, C_REF, 13'h0000);
    rst[0] = 1'b1;
    k = 0;
    while (cyc[0] != 18 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (cyc[0] != 18) begin
      errors++;
      $display("FAIL timeout_cyc18 dut0: got cyc=%0d, expected 18", cyc[0]);
    end
    hold_reset(0, 1);
    push_short_seq();
    rst[0] = 1'b1;
    wait_done(0, 100);
    for (int j = 0; j < 20; j++) tick();
    hold_reset(0, 2);
    push_short_seq();
    rst[0] = 1'b1;
    wait_done(0, 100);
    for (int j = 0; j < 20; j++) tick();
  endtask

  task automatic run1();
    hold_reset(1, 3);
    push(1, 1'b0, 2, C_PRE, 13'h0400);
    push(1, 1'b0, 4, C_REF, 13'h0000);
    push(1, 1'b0, 6, C_MRS, 13'h0037);
    push(1, 1'b1, 8, C_NOP, 13'h0000);
    rst[1] = 1'b1;
    wait_done(1, 50);
    for (int j = 0; j < 20; j++) tick();
  endtask

  task automatic run2();
    hold_reset(2, 4);
    push(2, 1'b0, 26600, C_PRE, 13'h0400);
    for (int r = 0; r < 8; r++) push(2, 1'b0, 26603 + 10 * r, C_REF, 13'h0000);
    push(2, 1'b0, 26683, C_MRS, 13'h0037);
    push(2, 1'b1, 26686, C_NOP, 13'h0000);
    rst[2] = 1'b1;
    wait_done(2, 27000);
    for (int j = 0; j < 50; j++) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b0;
      samp[i]      = 1'b0;
      cyc[i]       = -1;
      prev_done[i] = 1'b0;
    end
    fork
      run0();
      run1();
      run2();
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain dut%0d: got %0d pending events, expected 0", i, exp_q[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
